// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port sequencer in front of the SISC data memory.
// m0 is the CPU load/store path, m1 the test/DMA loader. Each granted
// transaction is a single word; writes produce a one-cycle dm_we pulse
// whose falling edge commits the word, and completions return a
// one-cycle ack with read data held on the port afterwards.
module dm_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 32,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] dm_read_addr,
  output logic [AW-1:0] dm_write_addr,
  output logic [DW-1:0] dm_write_data,
  output logic          dm_we,
  input  logic [DW-1:0] dm_read_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;            // granted port: 0 = m0, 1 = m1
  logic          last_gnt_q, last_gnt_d;  // port granted most recently
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          dm_we_q, dm_we_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic          pick_m1_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  // Arbitration: a lone requester wins; a tie goes to the port that was
  // not granted last, or always to m0 when fixed priority is selected.
  always_comb begin
    pick_m1_s = 1'b0;
    if (m0_req && m1_req) begin
      if (FIXED_PRI) begin
        pick_m1_s = 1'b0;
      end else begin
        pick_m1_s = ~last_gnt_q;
      end
    end else if (m1_req) begin
      pick_m1_s = 1'b1;
    end else begin
      pick_m1_s = 1'b0;
    end
  end

  // Mux the request fields of the winning port.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = {AW{1'b0}};
    sel_wdata_s = {DW{1'b0}};
    if (pick_m1_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

  // Sequencer next-state: request inputs are only looked at in IDLE, the
  // latched address/data registers double as the memory-side outputs.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    dm_we_d    = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d      = pick_m1_s;
          last_gnt_d = pick_m1_s;
          if (sel_we_s) begin
            wr_addr_d = sel_addr_s;
            wr_data_d = sel_wdata_s;
            dm_we_d   = 1'b1;
            state_d   = S_WR_HI;
          end else begin
            rd_addr_d = sel_addr_s;
            state_d   = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (gnt_q) begin
          m1_rdata_d = dm_read_data;
          m1_ack_d   = 1'b1;
        end else begin
          m0_rdata_d = dm_read_data;
          m0_ack_d   = 1'b1;
        end
        state_d = S_ACK;
      end
      S_WR_HI: begin
        // dm_we drops at this edge; that falling edge commits the word.
        dm_we_d = 1'b0;
        state_d = S_WR_LO;
      end
      S_WR_LO: begin
        if (gnt_q) begin
          m1_ack_d = 1'b1;
        end else begin
          m0_ack_d = 1'b1;
        end
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      rd_addr_q  <= {AW{1'b0}};
      wr_addr_q  <= {AW{1'b0}};
      wr_data_q  <= {DW{1'b0}};
      dm_we_q    <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= {DW{1'b0}};
      m1_rdata_q <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      dm_we_q    <= dm_we_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign dm_read_addr  = rd_addr_q;
  assign dm_write_addr = wr_addr_q;
  assign dm_write_data = wr_data_q;
  assign dm_we         = dm_we_q;
  assign m0_ack        = m0_ack_q;
  assign m1_ack        = m1_ack_q;
  assign m0_rdata      = m0_rdata_q;
  assign m1_rdata      = m1_rdata_q;

endmodule
